// File: rtl/sodor_mon_pkg.sv
// Shared types and helpers for the two-copy divergence monitor.
package sodor_mon_pkg;

   localparam int unsigned MAX_CH       = 16;
   localparam int unsigned MAX_CH_W     = 128;
   localparam int unsigned CH_IDX_MAX_W = 4;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      WARM = 2'd1,
      CHK  = 2'd2,
      DONE = 2'd3
   } mon_state_e;

   // Valid disagreement always counts; data only when both valid and masked in.
   function automatic logic chan_mismatch(input logic                va,
                                          input logic                vb,
                                          input logic [MAX_CH_W-1:0] da,
                                          input logic [MAX_CH_W-1:0] db,
                                          input logic                m);
      return (va ^ vb) | (va & vb & m & (da != db));
   endfunction

   function automatic logic [CH_IDX_MAX_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
      logic [CH_IDX_MAX_W-1:0] idx;
      idx = '0;
      for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
         if (v[i]) idx = CH_IDX_MAX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sodor_mon_ch_cmp.sv
// One observation-channel comparator; mismatch is forced low outside the check window.
module sodor_mon_ch_cmp
   import sodor_mon_pkg::*;
#(
   parameter int unsigned CH_W = 32
) (
   input  logic            valid_a,
   input  logic            valid_b,
   input  logic [CH_W-1:0] data_a,
   input  logic [CH_W-1:0] data_b,
   input  logic            mask,
   input  logic            in_window,
   output logic            mismatch_c
);

   assign mismatch_c = in_window &
                       chan_mismatch(valid_a, valid_b,
                                     MAX_CH_W'(data_a), MAX_CH_W'(data_b), mask);

endmodule

// File: rtl/sodor_diverge_monitor.sv
// Self-composition monitor: sequences core reset and records divergence of copy A vs copy B.
// Optional macro SODOR_DIVERGE_ASSERT_EN adds formal assert/assume hooks.
module sodor_diverge_monitor
   import sodor_mon_pkg::*;
#(
   parameter  int unsigned NUM_CH       = 4,
   parameter  int unsigned CH_W         = 32,
   parameter  int unsigned RESET_CYCLES = 2,
   parameter  int unsigned CHECK_START  = 8,
   parameter  int unsigned CHECK_END    = 18,
   parameter  int unsigned CNT_W        = 5,
   localparam int unsigned CH_IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   output logic                   core_reset,
   input  logic [NUM_CH-1:0]      obs_valid_a,
   input  logic [NUM_CH-1:0]      obs_valid_b,
   input  logic [NUM_CH*CH_W-1:0] obs_data_a,
   input  logic [NUM_CH*CH_W-1:0] obs_data_b,
   input  logic [NUM_CH-1:0]      data_cmp_mask,
   output logic [CNT_W-1:0]       cycle,
   output logic                   in_window,
   output logic                   diverge,
   output logic                   diverge_sticky,
   output logic [CNT_W-1:0]       first_cycle,
   output logic [CH_IDX_W-1:0]    first_ch,
   output logic                   done
);

   localparam logic [CNT_W-1:0] CYC_MAX   = '1;
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(CHECK_START - 1);
   localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHECK_END);

   mon_state_e        state, state_nxt;
   logic [NUM_CH-1:0] mm_c;
   logic              any_mm_c;

   // Saturating cycle counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              cycle <= '0;
      else if (cycle != CYC_MAX) cycle <= cycle + CNT_W'(1);
   end

   // State register; core_reset/done are registered decodes of the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RST;
         core_reset <= 1'b1;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         core_reset <= (state_nxt == RST);
         done       <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RST:     if (cycle == RST_LAST)  state_nxt = WARM;
         WARM:    if (cycle == WARM_LAST) state_nxt = CHK;
         CHK:     if (cycle == CHK_LAST)  state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = RST;
      endcase
   end

   assign in_window = (state == CHK);

   for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
      sodor_mon_ch_cmp #(.CH_W(CH_W)) u_cmp (
         .valid_a    (obs_valid_a[gi]),
         .valid_b    (obs_valid_b[gi]),
         .data_a     (obs_data_a[gi*CH_W +: CH_W]),
         .data_b     (obs_data_b[gi*CH_W +: CH_W]),
         .mask       (data_cmp_mask[gi]),
         .in_window  (in_window),
         .mismatch_c (mm_c[gi])
      );
   end

   assign any_mm_c = |mm_c;

   // Divergence capture: first_* frozen once sticky is set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         diverge        <= 1'b0;
         diverge_sticky <= 1'b0;
         first_cycle    <= '0;
         first_ch       <= '0;
      end else begin
         diverge <= any_mm_c;
         if (any_mm_c && !diverge_sticky) begin
            diverge_sticky <= 1'b1;
            first_cycle    <= cycle;
            first_ch       <= CH_IDX_W'(lowest_set(MAX_CH'(mm_c)));
         end
      end
   end

`ifdef SODOR_DIVERGE_ASSERT_EN
   always @(posedge clk) begin
      if (reset_n && state == DONE) assert (!diverge_sticky);
      if (reset_n && state == RST)  assume (obs_valid_a == obs_valid_b);
   end
`endif

endmodule

// File: tb/tb_sodor_diverge_monitor.sv
// Directed bench for sodor_diverge_monitor with default parameters.
module tb_sodor_diverge_monitor;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         core_reset;
   logic [3:0]   va, vb, mask;
   logic [127:0] da, db;
   logic [4:0]   cycle, first_cycle;
   logic         in_window, diverge, diverge_sticky, done;
   logic [1:0]   first_ch;

   int total = 0;
   int bad   = 0;
   int tcyc  = 0;

   always #5 clk = ~clk;

   sodor_diverge_monitor dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .core_reset     (core_reset),
      .obs_valid_a    (va),
      .obs_valid_b    (vb),
      .obs_data_a     (da),
      .obs_data_b     (db),
      .data_cmp_mask  (mask),
      .cycle          (cycle),
      .in_window      (in_window),
      .diverge        (diverge),
      .diverge_sticky (diverge_sticky),
      .first_cycle    (first_cycle),
      .first_ch       (first_ch),
      .done           (done)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-scenario inputs for cycle c; baseline is two identical copies.
   task automatic drive(input int scn, input int c);
      va = '1; vb = '1; mask = '1;
      for (int i = 0; i < 4; i++) begin
         da[i*32 +: 32] = 32'(c * 16 + i);
         db[i*32 +: 32] = 32'(c * 16 + i);
      end
      case (scn)
         2, 3: begin
            mask = (scn == 2) ? 4'b0100 : 4'b0000;
            if (c == 10) begin
               da[64 +: 32] = 32'h64;
               db[64 +: 32] = 32'h68;
            end
         end
         4: begin
            if (c == 12) begin vb[3] = 1'b0; vb[1] = 1'b0; end
            if (c == 14) vb[0] = 1'b0;
         end
         5: if (c == 7 || c == 0) vb[0] = 1'b0;
         6: if (c == 18) vb[2] = 1'b0;
         7: if (c == 19) vb[2] = 1'b0;
         8: if (c == 9) va[1] = 1'b0;
         default: ;
      endcase
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " core_reset"}, int'(core_reset), 1);
      check({tag, " cycle"},      int'(cycle), 0);
      check({tag, " in_window"},  int'(in_window), 0);
      check({tag, " diverge"},    int'(diverge), 0);
      check({tag, " sticky"},     int'(diverge_sticky), 0);
      check({tag, " first_cycle"},int'(first_cycle), 0);
      check({tag, " first_ch"},   int'(first_ch), 0);
      check({tag, " done"},       int'(done), 0);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      drive(1, 0);
      @(negedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk);
      reset_n = 1'b1;
      tcyc = 0;
   endtask

   // d1/d2: cycles where diverge is expected high; stk: first cycle with sticky set.
   task automatic run(input int scn, input int ncyc, input int d1, input int d2,
                      input int stk, input int fc, input int fch);
      string t;
      apply_reset();
      for (int k = 0; k < ncyc; k++) begin
         drive(scn, tcyc);
         @(posedge clk);
         #1 tcyc++;
         t = $sformatf("s%0d c%0d", scn, tcyc);
         check({t, " cycle"},      int'(cycle), (tcyc > 31) ? 31 : tcyc);
         check({t, " core_reset"}, int'(core_reset), (tcyc < 2) ? 1 : 0);
         check({t, " in_window"},  int'(in_window), (tcyc >= 8 && tcyc <= 18) ? 1 : 0);
         check({t, " done"},       int'(done), (tcyc >= 19) ? 1 : 0);
         check({t, " diverge"},    int'(diverge), (tcyc == d1 || tcyc == d2) ? 1 : 0);
         check({t, " sticky"},     int'(diverge_sticky), (tcyc >= stk) ? 1 : 0);
         check({t, " first_cycle"},int'(first_cycle), (tcyc >= stk) ? fc : 0);
         check({t, " first_ch"},   int'(first_ch), (tcyc >= stk) ? fch : 0);
      end
   endtask

   localparam int NEVER = 999;

   initial begin
      drive(1, 0);
      run(1, 34, NEVER, NEVER, NEVER, 0, 0);   // identical copies, saturation
      run(2, 22, 11, NEVER, 11, 10, 2);        // masked data mismatch on ch2
      run(3, 22, NEVER, NEVER, NEVER, 0, 0);   // same stimulus, data compare off
      run(4, 22, 13, 15, 13, 12, 1);           // ch3+ch1 then ch0
      run(5, 22, NEVER, NEVER, NEVER, 0, 0);   // before window: ignored
      run(6, 22, 19, NEVER, 19, 18, 2);        // last checked cycle
      run(7, 22, NEVER, NEVER, NEVER, 0, 0);   // after window: ignored
      run(8, 12, 10, NEVER, 10, 9, 1);         // mismatch then reset mid-window
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midreset");
      run(1, 22, NEVER, NEVER, NEVER, 0, 0);   // clean rerun
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
